// File: rtl/signed_sat_accumulator.sv
// signed_sat_accumulator
// Sums each frame of LEN signed W-bit samples and reports the frame sum plus a
// sticky flag that is set if any addition in the frame overflowed. Valid/ready
// handshakes on both sides; one result is held until the consumer takes it.
// Build option: define SIGNED_SAT_ACCUMULATOR_SATURATE_EN to clamp the running
// sum on overflow instead of letting it wrap.
module signed_sat_accumulator #(
  parameter int W   = 4,
  parameter int LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_sum,
  output logic                out_overflow
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sticky_q, sticky_d;
  logic signed [W-1:0]   out_sum_q, out_sum_d;
  logic                  out_ovf_q, out_ovf_d;
  logic                  out_valid_q, out_valid_d;

  logic signed [W:0]     sum_ext;
  logic                  ovf;
  logic signed [W-1:0]   acc_next;
  logic                  take;

`ifdef SIGNED_SAT_ACCUMULATOR_SATURATE_EN
  // Clamp toward the rail the operands were heading for; an overflow can only
  // happen when both operands share the accumulator's sign.
  function automatic logic signed [W-1:0] resolve_acc(
    input logic signed [W-1:0] wrapped,
    input logic                overflowed,
    input logic                acc_neg
  );
    if (!overflowed)
      return wrapped;
    else if (!acc_neg)
      return {1'b0, {(W-1){1'b1}}};
    else
      return {1'b1, {(W-1){1'b0}}};
  endfunction
`else
  // Wrap-around: keep the low W bits, matching the upstream adder stage.
  function automatic logic signed [W-1:0] resolve_acc(
    input logic signed [W-1:0] wrapped
  );
    return wrapped;
  endfunction
`endif

  // Datapath and next-state decode for the accumulate / hold handshake.
  always_comb begin
    sum_ext = {acc_q[W-1], acc_q} + {in_data[W-1], in_data};
    ovf     = (acc_q[W-1] == in_data[W-1]) && (sum_ext[W-1] != sum_ext[W]);
`ifdef SIGNED_SAT_ACCUMULATOR_SATURATE_EN
    acc_next = resolve_acc(sum_ext[W-1:0], ovf, acc_q[W-1]);
`else
    acc_next = resolve_acc(sum_ext[W-1:0]);
`endif
    take = in_valid && (state_q == ST_ACCUM);

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_ACCUM: begin
        if (take) begin
          if (cnt_q == CNT_LAST) begin
            // Final sample goes straight to the output registers.
            out_sum_d   = acc_next;
            out_ovf_d   = sticky_q | ovf;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
            acc_d       = '0;
            cnt_d       = '0;
            sticky_d    = 1'b0;
          end else begin
            acc_d    = acc_next;
            sticky_d = sticky_q | ovf;
            cnt_d    = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // No sample is taken in the cycle the result leaves.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = (state_q == ST_ACCUM);
  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Testbench for signed_sat_accumulator (W=4, LEN=4). Expected frame results
// come from an integer-arithmetic reference model; honours
// SIGNED_SAT_ACCUMULATOR_SATURATE_EN when the design is built with it.
module tb_signed_sat_accumulator;

  localparam int W    = 4;
  localparam int LEN  = 4;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_sum;
  logic                out_overflow;

  int checks   = 0;
  int failures = 0;

  signed_sat_accumulator #(.W(W), .LEN(LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer running sum, out-of-range means overflow.
  function automatic void model_frame(input int s[LEN], output int sum, output bit ovf);
    int acc;
    int t;
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      t = acc + s[i];
      if (t > MAXV || t < MINV) begin
        ovf = 1'b1;
`ifdef SIGNED_SAT_ACCUMULATOR_SATURATE_EN
        t = (t > MAXV) ? MAXV : MINV;
`else
        t = (t > MAXV) ? t - (1 << W) : t + (1 << W);
`endif
      end
      acc = t;
    end
    sum = acc;
  endfunction

  // Offer one sample and hold it until accepted.
  task automatic push(input int d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = W'(d);
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
        failures++;
        $fatal(1, "push timeout");
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  // Wait for a result, stall `delay` cycles, then take it.
  task automatic get_result(input int delay, output logic signed [W-1:0] sum, output logic ovf);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 100) begin
        $display("FAIL result_timeout out_valid=%0b required=1", out_valid);
        failures++;
        $fatal(1, "result timeout");
      end
    end
    repeat (delay) @(negedge clk);
    sum = out_sum;
    ovf = out_overflow;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b required=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b required=1", in_ready); end
    checks++;
    if (out_sum !== W'(0)) begin failures++; $display("FAIL reset_out_sum got=%0d required=0", out_sum); end
    checks++;
    if (out_overflow !== 1'b0) begin failures++; $display("FAIL reset_out_overflow got=%0b required=0", out_overflow); end
  endtask

  task automatic test_basic();
    logic signed [W-1:0] s;
    logic o;
    push(1); push(2); push(-1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b required=0", out_valid); end
    push(3);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency out_valid=%0b required=1", out_valid); end
    get_result(0, s, o);
    checks++;
    if (s !== W'(5)) begin failures++; $display("FAIL basic_sum got=%0d required=5", s); end
    checks++;
    if (o !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%0b required=0", o); end
  endtask

  task automatic test_overflow_frames();
    logic signed [W-1:0] s;
    logic o;
    int e1, e2;
`ifdef SIGNED_SAT_ACCUMULATOR_SATURATE_EN
    e1 = 6;  e2 = -8;
`else
    e1 = -6; e2 = 5;
`endif
    push(7); push(4); push(-2); push(1);
    get_result(1, s, o);
    checks++;
    if (s !== W'(e1)) begin failures++; $display("FAIL pos_ovf_sum got=%0d required=%0d", s, e1); end
    checks++;
    if (o !== 1'b1) begin failures++; $display("FAIL pos_ovf_flag got=%0b required=1", o); end
    push(-4); push(-7); push(0); push(0);
    get_result(0, s, o);
    checks++;
    if (s !== W'(e2)) begin failures++; $display("FAIL neg_ovf_sum got=%0d required=%0d", s, e2); end
    checks++;
    if (o !== 1'b1) begin failures++; $display("FAIL neg_ovf_flag got=%0b required=1", o); end
  endtask

  task automatic test_backpressure();
    logic signed [W-1:0] s;
    logic o;
    int e;
`ifdef SIGNED_SAT_ACCUMULATOR_SATURATE_EN
    e = 7;
`else
    e = -8;
`endif
    push(1); push(1); push(1); push(1);
    // Keep offering a sample while stalled; it must not be taken.
    in_valid = 1'b1;
    in_data  = W'(7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%0b required=1", i, out_valid); end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%0b required=0", i, in_ready); end
      checks++;
      if (out_sum !== W'(4)) begin failures++; $display("FAIL bp_sum cyc=%0d got=%0d required=4", i, out_sum); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%0b required=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b required=1", in_ready); end
    push(2); push(2); push(2); push(2);
    get_result(0, s, o);
    checks++;
    if (s !== W'(e)) begin failures++; $display("FAIL bp_next_sum got=%0d required=%0d", s, e); end
    checks++;
    if (o !== 1'b1) begin failures++; $display("FAIL bp_next_ovf got=%0b required=1", o); end
  endtask

  task automatic test_gapped();
    logic signed [W-1:0] s;
    logic o;
    push(3);
    for (int i = 0; i < 2; i++) begin
      in_data = W'($urandom);
      @(posedge clk);
      #1;
    end
    push(3); push(0);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL gap_spurious_valid got=%0b required=0", out_valid); end
    push(0);
    get_result(0, s, o);
    checks++;
    if (s !== W'(6)) begin failures++; $display("FAIL gap_sum got=%0d required=6", s); end
    checks++;
    if (o !== 1'b0) begin failures++; $display("FAIL gap_ovf got=%0b required=0", o); end
  endtask

  task automatic test_reset_midframe();
    logic signed [W-1:0] s;
    logic o;
    push(5); push(5);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%0b required=0", out_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_after_valid got=%0b required=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%0b required=1", in_ready); end
    checks++;
    if (out_sum !== W'(0)) begin failures++; $display("FAIL rst_mid_out_sum got=%0d required=0", out_sum); end
    push(1); push(0); push(0); push(0);
    get_result(0, s, o);
    checks++;
    if (s !== W'(1)) begin failures++; $display("FAIL rst_mid_sum got=%0d required=1", s); end
    checks++;
    if (o !== 1'b0) begin failures++; $display("FAIL rst_mid_ovf got=%0b required=0", o); end
  endtask

  task automatic test_random();
    int smp[LEN];
    int esum;
    bit eovf;
    logic signed [W-1:0] s;
    logic o;
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < LEN; i++) begin
        smp[i] = int'($urandom_range(0, (1 << W) - 1)) + MINV;
        push(smp[i]);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      model_frame(smp, esum, eovf);
      get_result(int'($urandom_range(0, 3)), s, o);
      checks++;
      if (s !== W'(esum)) begin failures++; $display("FAIL rand_sum frame=%0d got=%0d required=%0d", f, s, esum); end
      checks++;
      if (o !== eovf) begin failures++; $display("FAIL rand_ovf frame=%0d got=%0b required=%0b", f, o, eovf); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow_frames();
    test_backpressure();
    test_gapped();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
